// File: rtl/sgm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sgm_pkg
// Description : Shared FSM encodings, penalty defaults and width helper
//               for the SGM sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package sgm_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_vblank = 2'd1;
    localparam logic [1:0] c_st_line   = 2'd2;
    localparam logic [1:0] c_st_hblank = 2'd3;

    localparam logic [7:0] P1_DEFAULT = 8'd15;
    localparam logic [7:0] P2_DEFAULT = 8'd100;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay_line
// Description : DEPTH-stage shift register with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sgm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sgm_sequencer
// Description : Frame/line sequencer for SGM path costs: pixel coordinates,
//               path-start strobes, frame-synchronous penalty update.
// Revision    : 1.0 - initial release
// ============================================================================
module sgm_sequencer
    import sgm_pkg::*;
#(
    parameter int         ROW_WIDTH  = 10,
    parameter int         COL_WIDTH  = 11,
    parameter int         START_COL  = 400,
    parameter int         PIPE_DELAY = 1,
    parameter logic [7:0] P1_DEFAULT = sgm_pkg::P1_DEFAULT,
    parameter logic [7:0] P2_DEFAULT = sgm_pkg::P2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 de_in,
    input  logic                 h_sync_in,
    input  logic                 v_sync_in,
    input  logic [7:0]           cfg_p1,
    input  logic [7:0]           cfg_p2,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [7:0]           p1_out,
    output logic [7:0]           p2_out,
    output logic [ROW_WIDTH-1:0] row_out,
    output logic [COL_WIDTH-1:0] col_out,
    output logic                 path_begin_h,
    output logic                 path_begin_v,
    output logic                 de_out,
    output logic                 h_sync_out,
    output logic                 v_sync_out,
    output logic [1:0]           state_out
);

    localparam logic [COL_WIDTH-1:0] c_start_col = COL_WIDTH'(START_COL);
    localparam logic [COL_WIDTH-1:0] c_col_max   = '1;
    localparam logic [ROW_WIDTH-1:0] c_row_max   = '1;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_vs_prev;
    logic [ROW_WIDTH-1:0] r_row;
    logic [COL_WIDTH-1:0] r_col;
    logic                 r_pend;
    logic [7:0]           r_pend_p1;
    logic [7:0]           r_pend_p2;
    logic [7:0]           r_p1;
    logic [7:0]           r_p2;
    logic [2:0]           w_dly;

    logic w_vs_rise;
    logic w_active;
    logic w_line_end;
    logic w_handshake;

    assign w_vs_rise   = v_sync_in & ~r_vs_prev;
    assign w_active    = (r_state != c_st_idle);
    assign w_line_end  = (r_state == c_st_line) & ~de_in & ~w_vs_rise;
    assign w_handshake = cfg_valid & cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A frame start overrides any de_in-driven transition.
    always_comb begin
        w_state_next = r_state;
        if (w_vs_rise) begin
            w_state_next = c_st_vblank;
        end else begin
            case (r_state)
                c_st_vblank, c_st_hblank: if (de_in)  w_state_next = c_st_line;
                c_st_line:                if (!de_in) w_state_next = c_st_hblank;
                default:                  w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        cfg_ready    = ~rst & ~r_pend;
        path_begin_h = ~rst & w_active & de_in & (r_col == c_start_col);
        path_begin_v = ~rst & w_active & de_in & (r_row == '0) & (r_col >= c_start_col);
        de_out       = ~rst & w_dly[0];
        h_sync_out   = ~rst & w_dly[1];
        v_sync_out   = ~rst & w_dly[2];
        state_out    = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            r_vs_prev <= v_sync_in;
            // col tracks the pixel on the bus: zero on the first active cycle.
            if (w_active && de_in) begin
                if (r_col != c_col_max) r_col <= r_col + 1'b1;
            end else begin
                r_col <= '0;
            end
            if (w_vs_rise) begin
                r_row <= '0;
            end else if (w_line_end && (r_row != c_row_max)) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    // Handshake needs an empty slot, so it never collides with an apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= 1'b0;
            r_pend_p1 <= '0;
            r_pend_p2 <= '0;
            r_p1      <= P1_DEFAULT;
            r_p2      <= P2_DEFAULT;
        end else if (w_handshake) begin
            r_pend    <= 1'b1;
            r_pend_p1 <= cfg_p1;
            r_pend_p2 <= cfg_p2;
        end else if (w_vs_rise && r_pend) begin
            r_pend <= 1'b0;
            r_p1   <= r_pend_p1;
            r_p2   <= r_pend_p2;
        end
    end

    assign p1_out  = r_p1;
    assign p2_out  = r_p2;
    assign row_out = r_row;
    assign col_out = r_col;

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_timing_dly (
        .clk    (clk),
        .rst    (rst),
        .i_data ({v_sync_in, h_sync_in, de_in}),
        .o_data (w_dly)
    );

endmodule
`default_nettype wire

// File: tb/tb_sgm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sgm_sequencer
// Description : Scoreboard bench for sgm_sequencer against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sgm_sequencer;

    localparam int RW      = 2;
    localparam int CW      = 3;
    localparam int SC      = 4;
    localparam int PD      = 3;
    localparam int ROW_MAX = (1 << RW) - 1;
    localparam int COL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, de_in, h_sync_in, v_sync_in, cfg_valid;
    logic [7:0]    cfg_p1, cfg_p2;
    logic          cfg_ready, path_begin_h, path_begin_v;
    logic          de_out, h_sync_out, v_sync_out;
    logic [7:0]    p1_out, p2_out;
    logic [RW-1:0] row_out;
    logic [CW-1:0] col_out;
    logic [1:0]    state_out;

    always #5 clk = ~clk;

    sgm_sequencer #(
        .ROW_WIDTH  (RW),
        .COL_WIDTH  (CW),
        .START_COL  (SC),
        .PIPE_DELAY (PD),
        .P1_DEFAULT (8'd15),
        .P2_DEFAULT (8'd100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .de_in        (de_in),
        .h_sync_in    (h_sync_in),
        .v_sync_in    (v_sync_in),
        .cfg_p1       (cfg_p1),
        .cfg_p2       (cfg_p2),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .p1_out       (p1_out),
        .p2_out       (p2_out),
        .row_out      (row_out),
        .col_out      (col_out),
        .path_begin_h (path_begin_h),
        .path_begin_v (path_begin_v),
        .de_out       (de_out),
        .h_sync_out   (h_sync_out),
        .v_sync_out   (v_sync_out),
        .state_out    (state_out)
    );

    typedef struct {
        bit chk_regs;
        int st, row, col, p1, p2;
        bit ready, pbh, pbv, deo, hso, vso;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Frame-level model: started = a frame has begun since reset,
    // in_line = inside active video, had_line = a line has ended this frame.
    bit       m_started, m_in_line, m_had_line, m_pend, m_prev_vs, m_prev_rst;
    int       m_row, m_col, m_p1, m_p2, m_np1, m_np2;
    bit [2:0] m_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit de, input bit hs, input bit vs,
                       input bit cv = 1'b0, input logic [7:0] a = 8'd0,
                       input logic [7:0] b = 8'd0);
        exp_t e;
        bit   rise;
        @(posedge clk);
        #1;
        rst = r; de_in = de; h_sync_in = hs; v_sync_in = vs;
        cfg_valid = cv; cfg_p1 = a; cfg_p2 = b;

        e.chk_regs = !r || m_prev_rst;
        e.st    = !m_started ? 0 : (m_in_line ? 2 : (m_had_line ? 3 : 1));
        e.row   = m_row;
        e.col   = m_col;
        e.p1    = m_p1;
        e.p2    = m_p2;
        e.ready = !r && !m_pend;
        e.pbh   = !r && m_started && de && (m_col == SC);
        e.pbv   = !r && m_started && de && (m_row == 0) && (m_col >= SC);
        {e.vso, e.hso, e.deo} = r ? 3'b000 : m_hist[0];
        exp_q.push_back(e);

        if (r) begin
            m_started = 0; m_in_line = 0; m_had_line = 0; m_pend = 0; m_prev_vs = 0;
            m_row = 0; m_col = 0; m_p1 = 15; m_p2 = 100;
            m_hist = '{3'b000, 3'b000, 3'b000};
        end else begin
            rise  = vs && !m_prev_vs;
            m_col = (m_started && de) ? ((m_col < COL_MAX) ? m_col + 1 : COL_MAX) : 0;
            if (rise) m_row = 0;
            else if (m_started && m_in_line && !de) m_row = (m_row < ROW_MAX) ? m_row + 1 : ROW_MAX;
            if (rise) begin
                m_started = 1; m_in_line = 0; m_had_line = 0;
            end else if (m_started) begin
                if (de) m_in_line = 1;
                else if (m_in_line) begin m_in_line = 0; m_had_line = 1; end
            end
            if (cv && !m_pend) begin
                m_pend = 1; m_np1 = a; m_np2 = b;
            end else if (rise && m_pend) begin
                m_pend = 0; m_p1 = m_np1; m_p2 = m_np2;
            end
            m_prev_vs = vs;
            void'(m_hist.pop_front());
            m_hist.push_back({vs, hs, de});
        end
        m_prev_rst = r;
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic vsync();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_regs) begin
                chk("state_out", 32'(state_out), mon_e.st);
                chk("row_out",   32'(row_out),   mon_e.row);
                chk("col_out",   32'(col_out),   mon_e.col);
                chk("p1_out",    32'(p1_out),    mon_e.p1);
                chk("p2_out",    32'(p2_out),    mon_e.p2);
            end
            chk("cfg_ready",    32'(cfg_ready),    32'(mon_e.ready));
            chk("path_begin_h", 32'(path_begin_h), 32'(mon_e.pbh));
            chk("path_begin_v", 32'(path_begin_v), 32'(mon_e.pbv));
            chk("de_out",       32'(de_out),       32'(mon_e.deo));
            chk("h_sync_out",   32'(h_sync_out),   32'(mon_e.hso));
            chk("v_sync_out",   32'(v_sync_out),   32'(mon_e.vso));
        end
    end

    initial begin
        rst = 1; de_in = 0; h_sync_in = 0; v_sync_in = 0;
        cfg_valid = 0; cfg_p1 = 0; cfg_p2 = 0;
        m_prev_rst = 0;
        m_hist = '{3'b000, 3'b000, 3'b000};

        repeat (3) cyc(1, 0, 0, 0);
        // de activity before any frame start must be ignored
        for (int i = 0; i < 6; i++) cyc(0, i[0], 0, 0);

        // frame 1: three 8-pixel lines, config accepted mid-frame
        vsync();
        line(8);
        cyc(0, 0, 0, 0, 1, 8'd20, 8'd80);
        line(8);
        line(8);
        cyc(0, 0, 0, 0);

        // frame 2: applies 20/80; saturating column and row
        vsync();
        line(10);
        repeat (4) line(8);

        // frame 3: handshake on the very cycle of the frame-start edge
        cyc(0, 0, 0, 1, 1, 8'd30, 8'd60);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        line(8);
        line(8);

        // frame 4: 30/60 applied, then reset in LINE with a pending config
        vsync();
        line(8);
        cyc(0, 0, 0, 0, 1, 8'd55, 8'd66);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        vsync();
        line(8);
        vsync();
        line(8);

        // randomized timing and configuration traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 120) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
                ($urandom % 12) == 0, ($urandom % 8) == 0,
                8'($urandom), 8'($urandom));
        end
        repeat (4) cyc(0, 0, 0, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
